// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle ARM core, one state per clock.
// Define MULTICYCLE_CTRL_MUL_EN to add the MULSTART/MULWAIT path for the multi-cycle multiplier.
module multicycle_ctrl (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        CondEx,
    input  logic        MCycleBusy,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic        ALUOp,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MCycleStart,
    output logic [3:0]  State
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9, MULSTART = 4'd10, MULWAIT = 4'd11
    } state_t;
    state_t state_q, state_d;
    logic [1:0] op;
    logic [3:0] rd;
    logic is_mul, no_write, ir_wr, pc_wr, reg_wr, mem_wr, mc_start;
    assign op = Instr[27:26];
    assign no_write = Instr[24:22] == 3'b101;
`ifdef MULTICYCLE_CTRL_MUL_EN
    assign is_mul = op == 2'b00 && Instr[25:24] == 2'b00 && Instr[7:4] == 4'b1001;
    logic unused_bits;
    assign unused_bits = ^{Instr[31:28], Instr[11:8], Instr[3:0]};
`else
    assign is_mul = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{Instr[31:28], Instr[11:4], Instr[3:0], MCycleBusy};
`endif
    // MUL keeps its destination in the Rn field
    assign rd = is_mul ? Instr[19:16] : Instr[15:12];
    always_ff @(posedge CLK) begin
        state_q <= Reset ? FETCH : state_d;
    end
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: state_d = is_mul ? MULSTART : op == 2'b01 ? MEMADR : op == 2'b10 ? BRANCH :
                              op == 2'b11 ? FETCH : Instr[25] ? EXECI : EXECR;
            MEMADR: state_d = Instr[20] ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXECR, EXECI: state_d = ALUWB;
`ifdef MULTICYCLE_CTRL_MUL_EN
            MULSTART: state_d = MULWAIT;
            MULWAIT:  state_d = MCycleBusy ? MULWAIT : ALUWB;
`endif
            default: state_d = FETCH;
        endcase
    end
    always_comb begin
        ir_wr = 1'b0;
        pc_wr = 1'b0;
        reg_wr = 1'b0;
        mem_wr = 1'b0;
        mc_start = 1'b0;
        AdrSrc = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b00;
        ResultSrc = 2'b00;
        ALUOp = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ResultSrc = 2'b10;
                ir_wr = 1'b1;
                pc_wr = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_wr = CondEx;
                pc_wr = CondEx && rd == 4'hF;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_wr = CondEx;
            end
            EXECR: ALUOp = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp = 1'b1;
            end
            ALUWB: begin
                ResultSrc = is_mul ? 2'b11 : 2'b00;
                reg_wr = CondEx && (is_mul || !no_write);
                pc_wr = CondEx && (is_mul || !no_write) && rd == 4'hF;
            end
            BRANCH: begin
                ALUSrcB = 2'b01;
                ResultSrc = 2'b10;
                pc_wr = CondEx;
            end
            MULSTART: mc_start = is_mul;
            default: ;
        endcase
    end
    // reset suppresses every strobe, including those of FETCH
    assign IRWrite = ir_wr && !Reset;
    assign PCWrite = pc_wr && !Reset;
    assign RegWrite = reg_wr && !Reset;
    assign MemWrite = mem_wr && !Reset;
    assign MCycleStart = mc_start && !Reset;
    assign State = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction streams checked against a path-level model.
module tb_multicycle_ctrl;
    logic        CLK = 1'b0;
    logic        Reset, CondEx, MCycleBusy;
    logic [31:0] Instr;
    logic        IRWrite, AdrSrc, ALUSrcA, ALUOp, PCWrite, RegWrite, MemWrite, MCycleStart;
    logic [1:0]  ALUSrcB, ResultSrc;
    logic [3:0]  State;
    int n_cmp = 0;
    int n_bad = 0;
`ifdef MULTICYCLE_CTRL_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    multicycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .Instr(Instr), .CondEx(CondEx), .MCycleBusy(MCycleBusy),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MCycleStart(MCycleStart), .State(State)
    );
    always #5 CLK = ~CLK;
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    // {State, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, IRWrite, PCWrite, RegWrite, MemWrite, MCycleStart}
    function automatic logic [15:0] obs();
        return {State, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, IRWrite, PCWrite, RegWrite, MemWrite, MCycleStart};
    endfunction
    function automatic logic [6:0] sel_of(input int s, input logic mul);
        case (s)
            0, 1:    return 7'b0_1_10_10_0;
            2:       return 7'b0_0_01_00_0;
            3, 5:    return 7'b1_0_00_00_0;
            4:       return 7'b0_0_00_01_0;
            6:       return 7'b0_0_00_00_1;
            7:       return 7'b0_0_01_00_1;
            8:       return mul ? 7'b0_0_00_11_0 : 7'b0;
            9:       return 7'b0_0_01_10_0;
            default: return 7'b0;
        endcase
    endfunction
    // Expected cycle-by-cycle trace of one instruction; returns its length in cycles.
    function automatic int model(input logic [31:0] ins, input logic c, input int n, output logic [255:0] tr);
        int st[$];
        logic [4:0] sb[$];
        logic mul, w;
        mul = MUL_EN && ins[27:25] == 3'b000 && ins[24] == 1'b0 && ins[7:4] == 4'b1001;
        st = {0, 1};
        sb = {5'b11000, 5'b00000};
        case (ins[27:26])
            2'b11: ;
            2'b10: begin st.push_back(9); sb.push_back({1'b0, c, 3'b000}); end
            2'b01: begin
                st.push_back(2); sb.push_back(5'b0);
                if (ins[20]) begin
                    st.push_back(3); sb.push_back(5'b0);
                    st.push_back(4); sb.push_back({1'b0, c && ins[15:12] == 4'hF, c, 2'b00});
                end else begin
                    st.push_back(5); sb.push_back({3'b000, c, 1'b0});
                end
            end
            default: begin
                if (mul) begin
                    st.push_back(10); sb.push_back(5'b00001);
                    for (int i = 0; i <= n; i++) begin st.push_back(11); sb.push_back(5'b0); end
                    st.push_back(8); sb.push_back({1'b0, c && ins[19:16] == 4'hF, c, 2'b00});
                end else begin
                    w = c && !(ins[24:21] == 4'b1010 || ins[24:21] == 4'b1011);
                    st.push_back(ins[25] ? 7 : 6); sb.push_back(5'b0);
                    st.push_back(8); sb.push_back({1'b0, w && ins[15:12] == 4'hF, w, 2'b00});
                end
            end
        endcase
        tr = '0;
        foreach (st[i]) tr = (tr << 16) | 256'({st[i][3:0], sel_of(st[i], mul), sb[i]});
        return st.size();
    endfunction
    // Entered and left just after a falling edge; records what the DUT shows each cycle.
    task automatic run_instr(input logic [31:0] ins, input logic c, input int n, input int steps,
                             output logic [255:0] tr);
        tr = '0;
        for (int k = 0; k < steps; k++) begin
            Instr = ins;
            CondEx = c;
            MCycleBusy = MUL_EN ? (k >= 3 && k < 3 + n) : 1'($urandom);
            #1;
            tr = (tr << 16) | 256'(obs());
            @(negedge CLK);
        end
    endtask
    task automatic test_reset();
        Reset = 1'b1; Instr = 32'hE0821003; CondEx = 1'b1; MCycleBusy = 1'b0;
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            n_cmp++;
            if (State !== 4'd0 || obs()[4:0] !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_hold: state/strobes got %0d/%b want 0/00000", State, obs()[4:0]);
            end
        end
        @(negedge CLK);
        Reset = 1'b0; #1;
        n_cmp++;
        if (State !== 4'd0 || obs()[4:0] !== 5'b11000) begin
            n_bad++;
            $display("FAIL reset_release: state/strobes got %0d/%b want 0/11000", State, obs()[4:0]);
        end
    endtask
    task automatic test_instr(input string name, input logic [31:0] ins, input logic c, input int n);
        logic [255:0] exp_tr, got_tr;
        int len;
        len = model(ins, c, n, exp_tr);
        run_instr(ins, c, n, len, got_tr);
        n_cmp++;
        if (got_tr !== exp_tr) begin
            n_bad++;
            $display("FAIL %s trace: got %h want %h", name, got_tr[175:0], exp_tr[175:0]);
        end
        #1;
        n_cmp++;
        if (State !== 4'd0) begin
            n_bad++;
            $display("FAIL %s length: state after %0d cycles got %0d want 0", name, len, State);
        end
    endtask
    task automatic test_directed();
        test_instr("add", 32'hE0821003, 1'b1, 0);
        test_instr("ldr", 32'hE5910004, 1'b1, 0);
        test_instr("ldr_pc", 32'hE591F004, 1'b1, 0);
        test_instr("str_condfail", 32'hE5810004, 1'b0, 0);
        test_instr("str", 32'hE5810004, 1'b1, 0);
        test_instr("branch", 32'hEA000002, 1'b1, 0);
        test_instr("branch_condfail", 32'hEA000002, 1'b0, 0);
        test_instr("cmp", 32'hE1510002, 1'b1, 0);
        test_instr("addi_condfail", 32'hE2821003, 1'b0, 0);
        test_instr("undef_op", 32'hEC000000, 1'b1, 0);
        test_instr("mul", 32'hE0000291, 1'b1, 6);
    endtask
    task automatic test_back_to_back();
        logic [31:0] ins;
        for (int i = 0; i < 40; i++) begin
            ins = $urandom;
            ins[27:26] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
            if (ins[27:26] == 2'b00 && $urandom_range(0, 2) == 0) begin
                ins[25:24] = 2'b00;
                ins[7:4] = 4'b1001;
            end
            test_instr("random", ins, 1'($urandom), $urandom_range(0, 5));
        end
    endtask
    task automatic test_reset_mid(input string name, input logic [31:0] ins, input int at);
        logic [255:0] exp_tr, got_tr;
        int len;
        len = model(ins, 1'b1, 6, exp_tr);
        run_instr(ins, 1'b1, 6, at, got_tr);
        Reset = 1'b1;
        MCycleBusy = MUL_EN;
        #1;
        n_cmp++;
        if (State !== exp_tr[(len - 1 - at) * 16 + 12 +: 4] || obs()[4:0] !== 5'b0) begin
            n_bad++;
            $display("FAIL %s reset_edge: state/strobes got %0d/%b want %0d/00000", name, State,
                     obs()[4:0], exp_tr[(len - 1 - at) * 16 + 12 +: 4]);
        end
        @(negedge CLK); #1;
        n_cmp++;
        if (State !== 4'd0 || obs()[4:0] !== 5'b0) begin
            n_bad++;
            $display("FAIL %s reset_after: state/strobes got %0d/%b want 0/00000", name, State, obs()[4:0]);
        end
        Reset = 1'b0;
        MCycleBusy = 1'b0;
        #1;
        n_cmp++;
        if (State !== 4'd0 || obs()[4:0] !== 5'b11000) begin
            n_bad++;
            $display("FAIL %s refetch: state/strobes got %0d/%b want 0/11000", name, State, obs()[4:0]);
        end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid("mul_wait", 32'hE0000291, MUL_EN ? 5 : 3);
        test_reset_mid("ldr_wb", 32'hE5910004, 4);
        test_instr("after_reset", 32'hE0821003, 1'b1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
